// File: rtl/gate_unit.sv
// Registered four-input reduction cell: AND, OR, odd parity and 3-of-4 majority.
// Define GATE_SYNC_EN to insert a 2-flop synchronizer on every operand.
module gate_unit (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic p,
  output logic q,
  output logic r,
  output logic s
);

  function automatic logic parity4(input logic [3:0] v);
    return v[3] ^ v[2] ^ v[1] ^ v[0];
  endfunction

  function automatic logic [2:0] ones4(input logic [3:0] v);
    return {2'b00, v[3]} + {2'b00, v[2]} + {2'b00, v[1]} + {2'b00, v[0]};
  endfunction

  logic [3:0] opnd_s;
  logic [2:0] ones_s;
  logic       p_d, q_d, r_d, s_d;
  logic       p_q, q_q, r_q, s_q;

`ifdef GATE_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  // Two-stage synchronizer for operands from a foreign clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= {a, b, c, d};
      sync2_q <= sync1_q;
    end
  end

  assign opnd_s = sync2_q;
`else
  assign opnd_s = {a, b, c, d};
`endif

  // Reduction functions, all derived from the operand popcount.
  always_comb begin
    ones_s = ones4(opnd_s);
    p_d    = 1'b0;
    q_d    = 1'b0;
    r_d    = 1'b0;
    s_d    = 1'b0;
    if (ones_s == 3'd4) begin
      p_d = 1'b1;
    end else begin
      p_d = 1'b0;
    end
    q_d = (ones_s != 3'd0);
    r_d = parity4(opnd_s);
    s_d = (ones_s >= 3'd3);
  end

  // Output register; reset state matches the function of operand 0000.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 1'b0;
      q_q <= 1'b0;
      r_q <= 1'b0;
      s_q <= 1'b0;
    end else begin
      p_q <= p_d;
      q_q <= q_d;
      r_q <= r_d;
      s_q <= s_d;
    end
  end

  assign p = p_q;
  assign q = q_q;
  assign r = r_q;
  assign s = s_q;

endmodule

// File: tb/tb_gate_unit.sv
// Self-checking bench for gate_unit: sample-history model plus literal spot checks.
module tb_gate_unit;

`ifdef GATE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic p, q, r, s;

  int vectors = 0;
  int miscompares = 0;

  gate_unit dut (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d),
    .p(p), .q(q), .r(r), .s(s)
  );

  always #5 clk = ~clk;

  // Expected {p,q,r,s} straight from the popcount rules.
  function automatic logic [3:0] rule_of(input logic [3:0] code);
    int k;
    k = $countones(code);
    return {k == 4, k >= 1, (k % 2) == 1, k >= 3};
  endfunction

  // History of operand codes sampled at the last LAT edges since reset.
  logic [3:0] hist [0:LAT-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) hist[i] <= 4'b0000;
    end else begin
      hist[0] <= {a, b, c, d};
      for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: pqrs got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    check("model", {p, q, r, s}, rule_of(hist[LAT-1]));
  end

  task automatic drive(input logic [3:0] code);
    @(posedge clk);
    #2;
    {a, b, c, d} = code;
  endtask

  logic [3:0] lit_code [0:3];
  logic [3:0] lit_exp  [0:3];

  initial begin
    lit_code[0] = 4'b0000; lit_exp[0] = 4'b0000;
    lit_code[1] = 4'b0001; lit_exp[1] = 4'b0110;
    lit_code[2] = 4'b0111; lit_exp[2] = 4'b0111;
    lit_code[3] = 4'b1111; lit_exp[3] = 4'b1101;

    // Reset held with all-ones operands.
    {a, b, c, d} = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("reset_hold", {p, q, r, s}, 4'b0000);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk); #1;
      check("reset_release_early", {p, q, r, s}, 4'b0000);
    end
    @(posedge clk); #1;
    check("reset_release", {p, q, r, s}, 4'b1101);

    // Exhaustive sweep, each code held 6 cycles.
    for (int code = 0; code < 16; code++) begin
      drive(code[3:0]);
      repeat (5) @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
        if (lit_code[j] == code[3:0]) check("sweep_literal", {p, q, r, s}, lit_exp[j]);
      end
    end

    // Latency: 0000 -> 1110, s must rise exactly LAT edges later.
    drive(4'b0000);
    repeat (LAT + 2) @(posedge clk);
    #2;
    {a, b, c, d} = 4'b1110;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      check("latency_s", {3'b000, s}, (i == LAT) ? 4'b0001 : 4'b0000);
    end
    #1;
    check("latency_full", {p, q, r, s}, 4'b0111);

    // Async reset pulse between edges.
    drive(4'b1011);
    repeat (LAT + 1) @(posedge clk);
    #1;
    check("pre_async", {p, q, r, s}, 4'b0111);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_drop", {p, q, r, s}, 4'b0000);
    #3;
    rst_n = 1'b1;
    #1;
    check("async_hold_after_release", {p, q, r, s}, 4'b0000);

    // Parity toggling 0001/0011.
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 4'b0001 : 4'b0011);
      if (i >= LAT) begin
        #1;
        check("toggle_r", {p, q, r, 1'b0}, (i % 2 == LAT % 2) ? 4'b0110 : 4'b0100);
      end
    end

    // Randomized operands with occasional async reset pulses.
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rand_async", {p, q, r, s}, 4'b0000);
        #1;
        rst_n = 1'b1;
      end
    end

    repeat (LAT + 1) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
